instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameters SHALL be: MEM_SIZE default 5, depth in words; WORD_WIDTH default 32, instruction width; ADDR_LENGTH default 32, address width; BYTE_WIDTH default 8, input byte width; HALT_WORD default 32'hFFFFFFFF, end-of-program word.
REQ-002 Block SHALL use one clock, and reset SHALL be asynchronous and active-high.
REQ-003 i_Clk  input  1  clock, rising edge.
REQ-004 i_Reset  input  1  asynchronous active-high reset.
REQ-005 i_Start  input  1  single-cycle pulse that begins a program load at address 0.
REQ-006 i_Byte  input  BYTE_WIDTH  incoming program byte.
REQ-007 i_ByteValid  input  1  i_Byte is valid this cycle.
REQ-008 o_WrEn  output  1  one-cycle instruction-memory write strobe.
REQ-009 o_WrAddr  output  ADDR_LENGTH  word address of the write.
REQ-010 o_WrData  output  WORD_WIDTH  assembled instruction word.
REQ-011 o_Busy  output  1  high in LOAD.
REQ-012 o_Done  output  1  high in DONE.
REQ-013 o_Overflow  output  1  high in ERROR.
REQ-014 o_WordCount  output  ADDR_LENGTH  number of words written in the current load.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, DONE and ERROR.
REQ-016 Transitions: IDLE->LOAD on i_Start; LOAD->DONE on the cycle HALT_WORD is written; LOAD->ERROR on a completed word when o_WordCount==MEM_SIZE; DONE or ERROR->LOAD on i_Start.
REQ-017 i_Start in LOAD SHALL restart the load: byte counter, o_WordCount and address cleared, partial word discarded.
REQ-018 Bytes SHALL be accepted only in LOAD with i_ByteValid=1; bytes in other states SHALL be ignored.
REQ-019 Byte order SHALL be big-endian: the first byte of each group of 4 goes to bits [31:24], the last to [7:0].
REQ-020 A 2-bit byte counter SHALL wrap 3->0 on the 4th accepted byte.
REQ-021 o_WrEn SHALL pulse high exactly one cycle after the cycle the 4th byte is sampled, with o_WrData equal to the assembled word and o_WrAddr equal to o_WordCount before increment.
REQ-022 o_WordCount SHALL increment by 1 in the o_WrEn cycle.
REQ-023 A byte accepted during the o_WrEn cycle SHALL become byte 0 of the next word, and no byte SHALL be dropped at back-to-back rate.
REQ-024 HALT_WORD SHALL be written to memory like any other word; after that write the FSM SHALL enter DONE and ignore further bytes.
REQ-025 A word completed when o_WordCount==MEM_SIZE SHALL NOT be written (o_WrEn stays 0), and the FSM SHALL enter ERROR.
REQ-026 o_WrAddr, o_WrData and o_WordCount SHALL hold their last values outside write cycles.
REQ-027 All outputs SHALL be registered, and no output SHALL combinationally depend on inputs.

Reset
REQ-028 Reset SHALL force state IDLE, byte counter 0, shift register 0, and every output 0: o_WrEn, o_WrAddr, o_WrData, o_Busy, o_Done, o_Overflow and o_WordCount.
REQ-029 Reset asserted mid-load SHALL abort immediately, with no o_WrEn pulse afterwards; the partial word is lost.
REQ-030 After reset release, the block SHALL remain in IDLE until i_Start.

Structure
REQ-031 FSM state encodings, HALT_WORD and BYTES_PER_WORD=WORD_WIDTH/BYTE_WIDTH SHALL live in the shared processor package.
REQ-032 Byte assembly (shift register plus counter) SHALL be one sub-module, byte_packer, with a word-ready pulse output; the FSM and address logic stay in instruction_loader.

Verification
REQ-033 Reset, i_Start, then bytes 20,08,00,05 then FF,FF,FF,FF -> o_WrEn at addr 0 with 32'h20080005, then addr 1 with 32'hFFFFFFFF; o_Done=1; o_WordCount=2.
REQ-034 8 bytes on consecutive cycles, no gaps -> two o_WrEn pulses 4 cycles apart, both words correct, no byte lost.
REQ-035 MEM_SIZE=5, 6 non-halt words -> 5 writes at addrs 0..4, sixth word not written, o_Overflow=1, o_WrEn=0 afterwards.
REQ-036 Reset asserted after 2 bytes of a word -> outputs 0 immediately, no write; a new i_Start plus 4 bytes writes at addr 0.
REQ-037 i_Start during LOAD after 1 word plus 3 bytes -> next 4 bytes written at addr 0, o_WordCount=1.
REQ-038 Bytes with i_ByteValid=1 in IDLE and in DONE -> no o_WrEn, o_WordCount unchanged.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared constants for the program loader: FSM encodings, word geometry and
// the end-of-program marker.
package instruction_loader_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam int unsigned WORD_WIDTH_DEF = 32;
  localparam int unsigned BYTE_WIDTH_DEF = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_WIDTH_DEF / BYTE_WIDTH_DEF;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  localparam logic [WORD_WIDTH_DEF-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Big-endian byte-to-word assembler. The word and its ready strobe are
// presented in the same cycle as the final byte so the loader can register the write.
module byte_packer
  import instruction_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic [WORD_WIDTH-1:0] o_word_c,
  output logic                  o_word_ready_c
);

  localparam int unsigned SHIFT_W = WORD_WIDTH - BYTE_WIDTH;

  logic [BCNT_W-1:0]  r_cnt;
  logic [SHIFT_W-1:0] r_shift;
  logic               w_accept;

  assign w_accept       = i_en & i_valid;
  assign o_word_c       = {r_shift, i_byte};
  assign o_word_ready_c = w_accept && (r_cnt == BCNT_W'(BYTES_PER_WORD - 1));

  // Earlier bytes move toward the MSBs; the counter wraps naturally on the last byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_accept) begin
      r_cnt   <= r_cnt + BCNT_W'(1);
      r_shift <= o_word_c[SHIFT_W-1:0];
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Streams program bytes into instruction memory as words, stopping on the
// halt word or when memory is full.
module instruction_loader #(
  parameter int unsigned MEM_SIZE    = 5,
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned ADDR_LENGTH = 32,
  parameter int unsigned BYTE_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD = instruction_loader_pkg::DEFAULT_HALT_WORD
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic [BYTE_WIDTH-1:0]  i_Byte,
  input  logic                   i_ByteValid,
  output logic                   o_WrEn,
  output logic [ADDR_LENGTH-1:0] o_WrAddr,
  output logic [WORD_WIDTH-1:0]  o_WrData,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Overflow,
  output logic [ADDR_LENGTH-1:0] o_WordCount
);

  import instruction_loader_pkg::*;

  logic [1:0]             r_state;
  logic                   r_wr_en;
  logic [ADDR_LENGTH-1:0] r_wr_addr;
  logic [WORD_WIDTH-1:0]  r_wr_data;
  logic [ADDR_LENGTH-1:0] r_count;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overflow;

  logic [1:0]             w_state_next;
  logic                   w_wr_en_next;
  logic [ADDR_LENGTH-1:0] w_wr_addr_next;
  logic [WORD_WIDTH-1:0]  w_wr_data_next;
  logic [ADDR_LENGTH-1:0] w_count_next;
  logic                   w_pack_en;
  logic [WORD_WIDTH-1:0]  w_word;
  logic                   w_word_ready;

  // A start pulse wins over any byte arriving in the same cycle.
  assign w_pack_en = (r_state == S_LOAD) && !i_Start;

  byte_packer #(
    .WORD_WIDTH (WORD_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_byte_packer (
    .i_clk          (i_Clk),
    .i_rst          (i_Reset),
    .i_clear        (i_Start),
    .i_en           (w_pack_en),
    .i_valid        (i_ByteValid),
    .i_byte         (i_Byte),
    .o_word_c       (w_word),
    .o_word_ready_c (w_word_ready)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state    <= S_IDLE;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wr_en    <= w_wr_en_next;
      r_wr_addr  <= w_wr_addr_next;
      r_wr_data  <= w_wr_data_next;
      r_count    <= w_count_next;
      r_busy     <= (w_state_next == S_LOAD);
      r_done     <= (w_state_next == S_DONE);
      r_overflow <= (w_state_next == S_ERROR);
    end
  end

  // A completed word is written unless memory is already full.
  always_comb begin
    w_state_next   = r_state;
    w_wr_en_next   = 1'b0;
    w_wr_addr_next = r_wr_addr;
    w_wr_data_next = r_wr_data;
    w_count_next   = r_count;
    if (i_Start) begin
      w_state_next   = S_LOAD;
      w_wr_addr_next = '0;
      w_count_next   = '0;
    end else if ((r_state == S_LOAD) && w_word_ready) begin
      if (r_count == ADDR_LENGTH'(MEM_SIZE)) begin
        w_state_next = S_ERROR;
      end else begin
        w_wr_en_next   = 1'b1;
        w_wr_addr_next = r_count;
        w_wr_data_next = w_word;
        w_count_next   = r_count + ADDR_LENGTH'(1);
        if (w_word == HALT_WORD) begin
          w_state_next = S_DONE;
        end
      end
    end
  end

  assign o_WrEn      = r_wr_en;
  assign o_WrAddr    = r_wr_addr;
  assign o_WrData    = r_wr_data;
  assign o_WordCount = r_count;
  assign o_Busy      = r_busy;
  assign o_Done      = r_done;
  assign o_Overflow  = r_overflow;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a byte-queue model is checked against
// every output each cycle, and a write log is checked against hand-computed values.
module tb_instruction_loader;

  localparam int unsigned MEM  = 5;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        bvalid = 1'b0;
  logic [7:0]  bdata = 8'h00;
  logic        wren, busy, done, ovf;
  logic [31:0] waddr, wdata, wcount;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // model state: a simple "collected bytes" list plus status flags
  logic [7:0]  mq[$];
  logic        e_wren, e_busy, e_done, e_ovf;
  logic [31:0] e_addr, e_data, e_cnt;

  // write log captured from the DUT for literal checks
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  instruction_loader #(
    .MEM_SIZE    (MEM),
    .WORD_WIDTH  (32),
    .ADDR_LENGTH (32),
    .BYTE_WIDTH  (8),
    .HALT_WORD   (HALT)
  ) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Start     (start),
    .i_Byte      (bdata),
    .i_ByteValid (bvalid),
    .o_WrEn      (wren),
    .o_WrAddr    (waddr),
    .o_WrData    (wdata),
    .o_Busy      (busy),
    .o_Done      (done),
    .o_Overflow  (ovf),
    .o_WordCount (wcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_wren = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
    e_addr = '0;   e_data = '0;   e_cnt  = '0;
  endtask

  task automatic model_update();
    logic [31:0] w;
    if (rst) begin
      model_reset();
    end else begin
      e_wren = 1'b0;
      if (start) begin
        mq.delete();
        e_cnt = 0; e_addr = 0;
        e_busy = 1'b1; e_done = 1'b0; e_ovf = 1'b0;
      end else if (e_busy && bvalid) begin
        mq.push_back(bdata);
        if (mq.size() == 4) begin
          w = {mq[0], mq[1], mq[2], mq[3]};
          mq.delete();
          if (e_cnt == MEM) begin
            e_busy = 1'b0; e_ovf = 1'b1;
          end else begin
            e_wren = 1'b1; e_addr = e_cnt; e_data = w; e_cnt = e_cnt + 1;
            if (w == HALT) begin
              e_busy = 1'b0; e_done = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("wren",   {31'b0, wren}, {31'b0, e_wren});
    chk("waddr",  waddr,  e_addr);
    chk("wdata",  wdata,  e_data);
    chk("wcount", wcount, e_cnt);
    chk("busy",   {31'b0, busy}, {31'b0, e_busy});
    chk("done",   {31'b0, done}, {31'b0, e_done});
    chk("ovf",    {31'b0, ovf},  {31'b0, e_ovf});
    if (wren) begin
      log_addr.push_back(waddr);
      log_data.push_back(wdata);
      log_cyc.push_back(cyc);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] b);
    @(negedge clk);
    start = s; bvalid = v; bdata = b;
    @(posedge clk);
    model_update();
    #1;
    check_all();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; bvalid = 1'b0;
    model_reset();
    #1;
    check_all();
    idle(2);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();
    idle(3);

    // two-word program ending in the halt word, with gaps between bytes
    clear_log();
    step(1'b1, 1'b0, 8'h00);
    send(8'h20); idle(1); send(8'h08); send(8'h00); idle(2); send(8'h05);
    idle(1);
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    idle(2);
    chk("halt_nwrites", log_addr.size(), 2);
    if (log_addr.size() >= 2) begin
      chk("halt_addr0", log_addr[0], 32'd0);
      chk("halt_data0", log_data[0], 32'h2008_0005);
      chk("halt_addr1", log_addr[1], 32'd1);
      chk("halt_data1", log_data[1], 32'hFFFF_FFFF);
    end
    chk("halt_done",  {31'b0, done}, 32'd1);
    chk("halt_count", wcount, 32'd2);
    chk("model_count_pin", e_cnt, 32'd2);

    // bytes while DONE are ignored
    clear_log();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); idle(1);
    chk("done_nwrites", log_addr.size(), 0);
    chk("done_count",   wcount, 32'd2);

    // bytes while IDLE are ignored
    do_reset();
    clear_log();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); idle(1);
    chk("idle_nwrites", log_addr.size(), 0);
    chk("idle_count",   wcount, 32'd0);

    // back-to-back bytes, no gaps
    clear_log();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) send(8'(8'h11 + i));
    idle(2);
    chk("b2b_nwrites", log_addr.size(), 2);
    if (log_addr.size() >= 2) begin
      chk("b2b_data0", log_data[0], 32'h1112_1314);
      chk("b2b_data1", log_data[1], 32'h1516_1718);
      chk("b2b_addr1", log_addr[1], 32'd1);
      chk("b2b_gap",   32'(log_cyc[1] - log_cyc[0]), 32'd4);
    end

    // restart mid-word: partial word dropped, addressing restarts at 0
    clear_log();
    step(1'b1, 1'b0, 8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06); send(8'h07);
    step(1'b1, 1'b0, 8'h00);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    idle(1);
    chk("restart_nwrites", log_addr.size(), 2);
    if (log_addr.size() >= 2) begin
      chk("restart_addr", log_addr[1], 32'd0);
      chk("restart_data", log_data[1], 32'hA1A2_A3A4);
    end
    chk("restart_count", wcount, 32'd1);

    // overflow: six non-halt words into a five-word memory
    clear_log();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 24; i++) send(8'(i + 1));
    idle(2);
    chk("ovf_nwrites", log_addr.size(), 5);
    if (log_addr.size() >= 5) begin
      chk("ovf_addr4", log_addr[4], 32'd4);
      chk("ovf_data4", log_data[4], 32'h1112_1314);
      chk("ovf_addr0", log_addr[0], 32'd0);
    end
    chk("ovf_flag",  {31'b0, ovf}, 32'd1);
    chk("ovf_count", wcount, 32'd5);
    send(8'h21); send(8'h22); send(8'h23); send(8'h24); idle(1);
    chk("ovf_after_nwrites", log_addr.size(), 5);

    // reset in the middle of a word
    clear_log();
    step(1'b1, 1'b0, 8'h00);
    send(8'h31); send(8'h32);
    @(negedge clk);
    start = 1'b0; bvalid = 1'b1; bdata = 8'h33;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_busy",  {31'b0, busy}, 32'd0);
    chk("midrst_count", wcount, 32'd0);
    chk("midrst_data",  wdata,  32'd0);
    check_all();
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    step(1'b1, 1'b0, 8'h00);
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    idle(1);
    chk("midrst_nwrites", log_addr.size(), 1);
    if (log_addr.size() >= 1) begin
      chk("midrst_addr", log_addr[0], 32'd0);
      chk("midrst_wdata", log_data[0], 32'h4142_4344);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
